beep_pattern_gen: RTL and testbench

- Buzzer-side transmitter for the key/beep path. Accepts a beep-pattern request over a valid/ready handshake: N beeps, with on and off durations in ticks.
- During each on phase it drives a square-wave tone onto the buzzer pin. Between beeps it holds the pin inactive.
- Sits downstream of key-event logic (a key handler issues requests) and replaces direct level control of the buzzer.

---
 rtl/beep_pattern_gen_if.sv | 24 ++
 rtl/beep_pattern_gen.sv | 166 ++++++++++++++++
 tb/tb_beep_pattern_gen.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/beep_pattern_gen_if.sv
// Request channel for beep_pattern_gen: valid/ready handshake plus pattern fields.
interface beep_pattern_gen_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_count;
    logic [9:0] req_on_ticks;
    logic [9:0] req_off_ticks;

    modport master (
        output req_valid,
        output req_count,
        output req_on_ticks,
        output req_off_ticks,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_count,
        input  req_on_ticks,
        input  req_off_ticks,
        output req_ready
    );
endinterface

// File: rtl/beep_pattern_gen.sv
// Buzzer pattern transmitter: N tone bursts separated by silent gaps, timed in ticks.
// Optional BEEP_CONTINUOUS_EN: a count of 0 repeats ON/OFF until abort or reset.
module beep_pattern_gen #(
    parameter int TICK_CYCLES = 50000,
    parameter int TONE_HALF   = 9259,
    parameter bit BEEP_ACTIVE = 1'b1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    beep_pattern_gen_if.slave   req,
    input  logic                abort,
    output logic                beep,
    output logic                busy,
    output logic                done
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int HW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [HW-1:0] TONE_LAST = HW'(TONE_HALF - 1);

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t        state, state_next;
    logic [TW-1:0] tick_cnt, tick_next;
    logic [HW-1:0] tone_cnt, tone_next;
    logic [9:0]    dur_cnt, dur_next;
    logic [3:0]    remaining, remaining_next;
    logic [9:0]    on_len, on_len_next;
    logic [9:0]    off_len, off_len_next;
    logic          continuous, continuous_next;
    logic          beep_next, busy_next, done_next;
    logic          accept, tick_wrap, req_is_continuous;

    assign req.req_ready = (state == IDLE) && !abort && !sys_rst;
    assign accept        = req.req_valid && req.req_ready;
    assign tick_wrap     = (tick_cnt == TICK_LAST);

`ifdef BEEP_CONTINUOUS_EN
    assign req_is_continuous = (req.req_count == 4'd0);
`else
    assign req_is_continuous = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            tone_cnt   <= '0;
            dur_cnt    <= '0;
            remaining  <= '0;
            on_len     <= '0;
            off_len    <= '0;
            continuous <= 1'b0;
            beep       <= !BEEP_ACTIVE;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            tick_cnt   <= tick_next;
            tone_cnt   <= tone_next;
            dur_cnt    <= dur_next;
            remaining  <= remaining_next;
            on_len     <= on_len_next;
            off_len    <= off_len_next;
            continuous <= continuous_next;
            beep       <= beep_next;
            busy       <= busy_next;
            done       <= done_next;
        end
    end

    always_comb begin
        state_next      = state;
        tick_next       = tick_cnt;
        tone_next       = tone_cnt;
        dur_next        = dur_cnt;
        remaining_next  = remaining;
        on_len_next     = on_len;
        off_len_next    = off_len;
        continuous_next = continuous;
        beep_next       = beep;
        busy_next       = busy;
        done_next       = 1'b0;

        case (state)
            IDLE: begin
                beep_next = !BEEP_ACTIVE;
                busy_next = 1'b0;
                if (accept) begin
                    // Zero-length phases behave as one tick.
                    remaining_next  = req.req_count;
                    on_len_next     = (req.req_on_ticks == 10'd0) ? 10'd1 : req.req_on_ticks;
                    off_len_next    = (req.req_off_ticks == 10'd0) ? 10'd1 : req.req_off_ticks;
                    continuous_next = req_is_continuous;
                    tick_next       = '0;
                    tone_next       = '0;
                    dur_next        = '0;
                    if (req.req_count != 4'd0 || req_is_continuous) begin
                        state_next = ON;
                        beep_next  = BEEP_ACTIVE;
                        busy_next  = 1'b1;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end

            ON: begin
                tick_next = tick_wrap ? '0 : tick_cnt + 1'b1;
                if (tick_wrap) dur_next = dur_cnt + 10'd1;
                if (tone_cnt == TONE_LAST) begin
                    tone_next = '0;
                    beep_next = !beep;
                end else begin
                    tone_next = tone_cnt + 1'b1;
                end
                if (tick_wrap && dur_cnt == on_len - 10'd1) begin
                    tick_next = '0;
                    tone_next = '0;
                    dur_next  = '0;
                    beep_next = !BEEP_ACTIVE;
                    if (continuous || remaining > 4'd1) begin
                        if (!continuous) remaining_next = remaining - 4'd1;
                        state_next = OFF;
                    end else begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end
                end
            end

            OFF: begin
                beep_next = !BEEP_ACTIVE;
                tick_next = tick_wrap ? '0 : tick_cnt + 1'b1;
                if (tick_wrap) dur_next = dur_cnt + 10'd1;
                if (tick_wrap && dur_cnt == off_len - 10'd1) begin
                    state_next = ON;
                    tick_next  = '0;
                    tone_next  = '0;
                    dur_next   = '0;
                    beep_next  = BEEP_ACTIVE;
                end
            end

            default: begin
                state_next = IDLE;
                beep_next  = !BEEP_ACTIVE;
                busy_next  = 1'b0;
            end
        endcase

        // Abort overrides everything and silently drops the pattern.
        if (abort) begin
            state_next = IDLE;
            tick_next  = '0;
            tone_next  = '0;
            dur_next   = '0;
            beep_next  = !BEEP_ACTIVE;
            busy_next  = 1'b0;
            done_next  = 1'b0;
        end
    end

endmodule

// File: tb/tb_beep_pattern_gen.sv
// Self-checking bench for beep_pattern_gen with a cycle-indexed arithmetic pattern model.
// Define BEEP_CONTINUOUS_EN for both bench and RTL to exercise the continuous mode.
module tb_beep_pattern_gen;

    localparam int TICK = 10;
    localparam int TONE = 2;

    logic sys_clk;
    logic sys_rst;
    logic abort;
    logic beep;
    logic busy;
    logic done;

    int compared   = 0;
    int mismatched = 0;

    beep_pattern_gen_if req_if ();

    beep_pattern_gen #(
        .TICK_CYCLES (TICK),
        .TONE_HALF   (TONE),
        .BEEP_ACTIVE (1'b1)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .req     (req_if),
        .abort   (abort),
        .beep    (beep),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Expected {beep, busy, done} in cycle k after the accept cycle (k = 0).
    function automatic logic [2:0] model_out(int k, int c, int on, int off);
        int on_c, off_c, total, t, pos;
        on_c  = ((on == 0) ? 1 : on) * TICK;
        off_c = ((off == 0) ? 1 : off) * TICK;
        if (k < 1) return 3'b000;
        t = k - 1;
        if (c == 0) begin
`ifdef BEEP_CONTINUOUS_EN
            pos = t % (on_c + off_c);
            return {(pos < on_c) && ((pos / TONE) % 2 == 0), 1'b1, 1'b0};
`else
            return {1'b0, 1'b0, (k == 1)};
`endif
        end
        total = c * on_c + (c - 1) * off_c;
        if (t < total) begin
            pos = t % (on_c + off_c);
            return {(pos < on_c) && ((pos / TONE) % 2 == 0), 1'b1, 1'b0};
        end
        if (t == total) return 3'b001;
        return 3'b000;
    endfunction

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic observed, input logic expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input int c, input int on, input int off);
        req_if.req_valid     = valid;
        req_if.req_count     = 4'(c);
        req_if.req_on_ticks  = 10'(on);
        req_if.req_off_ticks = 10'(off);
    endtask

    // Presents a request in the current cycle and checks every following cycle.
    // Ends inside the done cycle (or a few idle cycles after a kill) so the next call can chain.
    task automatic run_pattern(input int c, input int on, input int off, input bit noise,
                               input int kill_k, input bit kill_rst);
        int on_c, off_c, endk;
        logic [2:0] exp;
        bit killed;
        on_c   = ((on == 0) ? 1 : on) * TICK;
        off_c  = ((off == 0) ? 1 : off) * TICK;
        killed = 1'b0;
        if (kill_k > 0) endk = kill_k + 5;
        else if (c == 0) endk = 1;
        else endk = c * on_c + (c - 1) * off_c + 1;

        abort   = 1'b0;
        sys_rst = 1'b0;
        apply_stimulus(1'b1, c, on, off);
        #1;
        check_output("ready_at_accept", req_if.req_ready, 1'b1);

        for (int k = 1; k <= endk; k++) begin
            step();
            abort   = 1'b0;
            sys_rst = 1'b0;
            exp = killed ? 3'b000 : model_out(k, c, on, off);
            if (noise && exp[1] && k != endk)
                apply_stimulus(1'b1, $urandom_range(0, 15), $urandom_range(0, 1023),
                               $urandom_range(0, 1023));
            else
                apply_stimulus(1'b0, 0, 0, 0);
            if (k == kill_k) begin
                if (kill_rst) sys_rst = 1'b1;
                else abort = 1'b1;
            end
            #1;
            check_output($sformatf("beep k=%0d", k), beep, exp[2]);
            check_output($sformatf("busy k=%0d", k), busy, exp[1]);
            check_output($sformatf("done k=%0d", k), done, exp[0]);
            check_output($sformatf("ready k=%0d", k), req_if.req_ready,
                         !exp[1] && (k != kill_k));
            if (k == kill_k) killed = 1'b1;
        end
        abort   = 1'b0;
        sys_rst = 1'b0;
        apply_stimulus(1'b0, 0, 0, 0);
    endtask

    initial begin
        int c, on, off;
        bit noise;

        sys_rst = 1'b1;
        abort   = 1'b0;
        apply_stimulus(1'b0, 0, 0, 0);
        step();
        step();
        check_output("rst_beep", beep, 1'b0);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_done", done, 1'b0);
        check_output("rst_ready", req_if.req_ready, 1'b0);
        sys_rst = 1'b0;
        #1;
        check_output("ready_after_rst", req_if.req_ready, 1'b1);

        $display("[TB] basic two-beep pattern with busy-time request noise");
        run_pattern(2, 3, 2, 1'b1, 0, 1'b0);
        $display("[TB] back-to-back request in done cycle, zero-length phases");
        run_pattern(1, 0, 0, 1'b0, 0, 1'b0);
        step();

`ifndef BEEP_CONTINUOUS_EN
        $display("[TB] zero-count request");
        run_pattern(0, 3, 2, 1'b0, 0, 1'b0);
        step();
`endif

        $display("[TB] abort mid-pattern");
        run_pattern(2, 3, 2, 1'b0, 15, 1'b0);

        $display("[TB] abort together with req_valid in IDLE");
        abort = 1'b1;
        apply_stimulus(1'b1, 2, 1, 1);
        #1;
        check_output("abort_idle_ready", req_if.req_ready, 1'b0);
        step();
        abort = 1'b0;
        apply_stimulus(1'b0, 0, 0, 0);
        #1;
        check_output("abort_idle_busy", busy, 1'b0);
        check_output("abort_idle_beep", beep, 1'b0);
        check_output("abort_idle_done", done, 1'b0);

        $display("[TB] reset mid-pattern");
        run_pattern(2, 3, 2, 1'b0, 40, 1'b1);

`ifdef BEEP_CONTINUOUS_EN
        $display("[TB] continuous pattern stopped by abort");
        run_pattern(0, 1, 1, 1'b0, 205, 1'b0);
`endif

        $display("[TB] randomized patterns");
        for (int i = 0; i < 10; i++) begin
`ifdef BEEP_CONTINUOUS_EN
            c = $urandom_range(1, 4);
`else
            c = $urandom_range(0, 4);
`endif
            on    = $urandom_range(0, 4);
            off   = $urandom_range(0, 4);
            noise = 1'($urandom_range(0, 1));
            run_pattern(c, on, off, noise, 0, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                step();
                apply_stimulus(1'b0, 0, 0, 0);
                #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
